// File: rtl/lint64_arb_pkg.sv
// Shared types and widths for the 64-bit LINT round-robin arbiter.
//   LINT64_ADDR_W / LINT64_DATA_W / LINT64_BE_W : bus field widths
//   lint64_req_t : request payload carried from the winning requester downstream
//   arb_state_e  : arbiter FSM states
package lint64_arb_pkg;

  localparam int unsigned LINT64_ADDR_W = 32;
  localparam int unsigned LINT64_DATA_W = 64;
  localparam int unsigned LINT64_BE_W   = 8;

  typedef struct packed {
    logic [LINT64_DATA_W-1:0] wdata;
    logic [LINT64_ADDR_W-1:0] add;
    logic                     wen;
    logic [LINT64_BE_W-1:0]   be;
    logic                     size;
  } lint64_req_t;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/lint64_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transfers.
//   clk, rst      : clock, asynchronous active-high reset
//   push_i/id_i   : store the ID of a newly granted transfer (ignored when full)
//   pop_i         : retire the head entry (ignored when empty)
//   full_o/empty_o: occupancy flags; head_o: oldest outstanding ID
// A pop never frees a slot for a push in the same cycle: push is gated on the
// registered full flag only.
module lint64_arb_id_fifo
  import lint64_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned IdW   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic [IdW-1:0] id_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output logic [IdW-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [IdW-1:0]  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read while occupied.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= id_i;
    end
  end

endmodule

// File: rtl/lint64_rr_arbiter.sv
// Round-robin arbiter sharing one 64-bit LINT master port among N_MASTERS
// requesters, with in-order response routing.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_i/gnt_o              : per-requester request / one-hot grant
//   wdata_i/add_i/wen_i/be_i/size_i : flattened per-requester payloads
//   r_valid_o/r_rdata_o      : per-requester response valid, broadcast data
//   req_o/gnt_i, wdata_o..size_o    : downstream request and winning payload
//   r_valid_i/r_rdata_i      : downstream response
//   err_o                    : sticky, response seen with no outstanding ID
// Optional macro LINT64_ARB_PERF_EN adds perf_clr_i, perf_gnt_cnt_o and
// perf_stall_cnt_o saturating counters.
module lint64_rr_arbiter
  import lint64_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_MASTERS-1:0]               req_i,
  output logic [N_MASTERS-1:0]               gnt_o,
  input  logic [N_MASTERS*LINT64_DATA_W-1:0] wdata_i,
  input  logic [N_MASTERS*LINT64_ADDR_W-1:0] add_i,
  input  logic [N_MASTERS-1:0]               wen_i,
  input  logic [N_MASTERS*LINT64_BE_W-1:0]   be_i,
  input  logic [N_MASTERS-1:0]               size_i,
  output logic [N_MASTERS-1:0]               r_valid_o,
  output logic [LINT64_DATA_W-1:0]           r_rdata_o,
  output logic                               req_o,
  input  logic                               gnt_i,
  output logic [LINT64_DATA_W-1:0]           wdata_o,
  output logic [LINT64_ADDR_W-1:0]           add_o,
  output logic                               wen_o,
  output logic [LINT64_BE_W-1:0]             be_o,
  output logic                               size_o,
  input  logic                               r_valid_i,
  input  logic [LINT64_DATA_W-1:0]           r_rdata_i,
  output logic                               err_o
`ifdef LINT64_ARB_PERF_EN
  ,
  input  logic                               perf_clr_i,
  output logic [N_MASTERS*16-1:0]            perf_gnt_cnt_o,
  output logic [15:0]                        perf_stall_cnt_o
`endif
);

  localparam int unsigned IdW = $clog2(N_MASTERS);

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] hold_id_q, hold_id_d;
  logic [IdW-1:0] winner, sel;
  logic           grant, fifo_full, fifo_empty, pop, err_q;
  logic [IdW-1:0] fifo_head;
  lint64_req_t    reqs [N_MASTERS];
  lint64_req_t    sel_req;

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
    assign reqs[g] = '{wdata: wdata_i[g*LINT64_DATA_W +: LINT64_DATA_W],
                       add:   add_i[g*LINT64_ADDR_W +: LINT64_ADDR_W],
                       wen:   wen_i[g],
                       be:    be_i[g*LINT64_BE_W +: LINT64_BE_W],
                       size:  size_i[g]};
  end

  // First active request at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    logic        found;
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      idx = (32'(rr_ptr_q) + i) % N_MASTERS;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = IdW'(idx);
      end
    end
  end

  // HOLD pins the mux to the latched winner so a partially granted request
  // never changes underneath the downstream split.
  assign sel     = (state_q == HOLD) ? hold_id_q : winner;
  assign req_o   = ((state_q == HOLD) ? req_i[hold_id_q] : |req_i) & ~fifo_full;
  assign grant   = req_o & gnt_i;
  assign gnt_o   = grant ? ({{(N_MASTERS-1){1'b0}}, 1'b1} << sel) : '0;
  assign sel_req = reqs[sel];

  assign wdata_o = sel_req.wdata;
  assign add_o   = sel_req.add;
  assign wen_o   = sel_req.wen;
  assign be_o    = sel_req.be;
  assign size_o  = sel_req.size;

  always_comb begin
    state_d   = state_q;
    hold_id_d = hold_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (sel == IdW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
    end
    if (state_q == ARB) begin
      if (req_o && !gnt_i) begin
        state_d   = HOLD;
        hold_id_d = winner;
      end
    end else if (grant) begin
      state_d = ARB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      hold_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_id_q <= hold_id_d;
      err_q     <= err_q | (r_valid_i & fifo_empty);
    end
  end

  lint64_arb_id_fifo #(
    .Depth (MAX_OUTSTANDING),
    .IdW   (IdW)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant),
    .id_i    (sel),
    .pop_i   (r_valid_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign pop       = r_valid_i & ~fifo_empty;
  assign r_valid_o = pop ? ({{(N_MASTERS-1){1'b0}}, 1'b1} << fifo_head) : '0;
  assign r_rdata_o = r_rdata_i;
  assign err_o     = err_q;

`ifdef LINT64_ARB_PERF_EN
  logic [15:0] perf_gnt_q [N_MASTERS];
  logic [15:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MASTERS; i++) perf_gnt_q[i] <= '0;
      perf_stall_q <= '0;
    end else if (perf_clr_i) begin
      for (int i = 0; i < N_MASTERS; i++) perf_gnt_q[i] <= '0;
      perf_stall_q <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (grant && sel == IdW'(i) && perf_gnt_q[i] != 16'hFFFF) begin
          perf_gnt_q[i] <= perf_gnt_q[i] + 16'd1;
        end
      end
      if (req_o && !gnt_i && perf_stall_q != 16'hFFFF) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < N_MASTERS; g++) begin : g_perf
    assign perf_gnt_cnt_o[g*16 +: 16] = perf_gnt_q[g];
  end
  assign perf_stall_cnt_o = perf_stall_q;
`endif

  // A held requester must stay asserted until it is granted.
  hold_req_kept_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == HOLD) |-> req_i[hold_id_q]);

endmodule

// File: tb/tb_lint64_rr_arbiter.sv
module tb_lint64_rr_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, gnt_o, wen_i, size_i, r_valid_o;
  logic [N*64-1:0] wdata_i;
  logic [N*32-1:0] add_i;
  logic [N*8-1:0]  be_i;
  logic [63:0]     r_rdata_o, wdata_o, r_rdata_i;
  logic            req_o, gnt_i, wen_o, size_o, r_valid_i, err_o;
  logic [31:0]     add_o;
  logic [7:0]      be_o;

  int checks   = 0;
  int failures = 0;
  int unsigned sb[$];

  lint64_rr_arbiter #(
    .N_MASTERS       (N),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .wdata_i   (wdata_i),
    .add_i     (add_i),
    .wen_i     (wen_i),
    .be_i      (be_i),
    .size_i    (size_i),
    .r_valid_o (r_valid_o),
    .r_rdata_o (r_rdata_o),
    .req_o     (req_o),
    .gnt_i     (gnt_i),
    .wdata_o   (wdata_o),
    .add_o     (add_o),
    .wen_o     (wen_o),
    .be_o      (be_o),
    .size_o    (size_o),
    .r_valid_i (r_valid_i),
    .r_rdata_i (r_rdata_i),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    req_i     = '0;
    gnt_i     = 1'b0;
    r_valid_i = 1'b0;
    r_rdata_i = '0;
  endtask

  task automatic load_fields();
    for (int i = 0; i < N; i++) begin
      add_i[i*32 +: 32]   = 32'h1000 * (i + 1);
      wdata_i[i*64 +: 64] = {32'hA5A5_0000 + i, 32'h5A5A_0000 + i};
      be_i[i*8 +: 8]      = 8'hFF;
    end
    wen_i  = '0;
    size_i = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    sb.delete();
    rst = 1'b1;
    #3;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    load_fields();
    #2;
    checks++;
    if (gnt_o !== 4'b0000) begin
      failures++; $display("FAIL reset_gnt: got %b want 0000", gnt_o);
    end
    checks++;
    if (r_valid_o !== 4'b0000) begin
      failures++; $display("FAIL reset_rvalid: got %b want 0000", r_valid_o);
    end
    checks++;
    if (req_o !== 1'b0) begin
      failures++; $display("FAIL reset_req: got %b want 0", req_o);
    end
    checks++;
    if (err_o !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b want 0", err_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle_req: got %b want 0", req_o);
    end
    next_cycle();
  endtask

  task automatic test_single_read();
    int unsigned e;
    add_i[1*32 +: 32] = 32'h0000_0100;
    wen_i[1]  = 1'b1;
    size_i[1] = 1'b1;
    req_i     = 4'b0010;
    gnt_i     = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b0010) begin
      failures++; $display("FAIL single_gnt: got %b want 0010", gnt_o);
    end
    checks++;
    if (add_o !== 32'h100 || wen_o !== 1'b1 || size_o !== 1'b1) begin
      failures++;
      $display("FAIL single_mux: got add=%h wen=%b size=%b want 100/1/1", add_o, wen_o, size_o);
    end
    if (gnt_o[1]) sb.push_back(1);
    next_cycle();
    idle();
    r_valid_i = 1'b1;
    r_rdata_i = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL single_sb: got no pending id want one");
    end else begin
      e = sb.pop_front();
      if (r_valid_o !== (4'b0001 << e)) begin
        failures++; $display("FAIL single_rvalid: got %b want %b", r_valid_o, 4'b0001 << e);
      end
    end
    checks++;
    if (r_rdata_o !== 64'hDEAD_BEEF_0123_4567) begin
      failures++; $display("FAIL single_rdata: got %h want deadbeef01234567", r_rdata_o);
    end
    next_cycle();
    idle();
    load_fields();
  endtask

  task automatic test_round_robin();
    int          order[5] = '{0, 1, 2, 3, 0};
    int          gcount[N];
    int unsigned e;
    logic [63:0] d;
    do_reset();
    for (int i = 0; i < N; i++) gcount[i] = 0;
    for (int k = 0; k < 5; k++) begin
      d         = 64'h1111_0000_0000_0000 + 64'(k);
      req_i     = 4'b1111;
      gnt_i     = 1'b1;
      r_valid_i = (k > 0);
      r_rdata_i = d;
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL rr_sb: got no pending id at cycle %0d", k);
        end else begin
          e = sb.pop_front();
          if (r_valid_o !== (4'b0001 << e) || r_rdata_o !== d) begin
            failures++;
            $display("FAIL rr_resp: got %b/%h want %b/%h", r_valid_o, r_rdata_o,
                     4'b0001 << e, d);
          end
        end
      end
      checks++;
      if (req_o !== 1'b1) begin
        failures++; $display("FAIL rr_req: got %b want 1 at cycle %0d", req_o, k);
      end
      checks++;
      if (gnt_o !== (4'b0001 << order[k])) begin
        failures++;
        $display("FAIL rr_gnt: got %b want %b at cycle %0d", gnt_o, 4'b0001 << order[k], k);
      end
      sb.push_back(order[k]);
      if (k < 4) for (int i = 0; i < N; i++) if (gnt_o[i]) gcount[i]++;
      next_cycle();
    end
    idle();
    r_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    e = (sb.size() > 0) ? sb.pop_front() : 99;
    if (r_valid_o !== (4'b0001 << e)) begin
      failures++; $display("FAIL rr_drain: got %b want id %0d", r_valid_o, e);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gcount[i] != 1) begin
        failures++; $display("FAIL rr_fair: got %0d grants want 1 for req %0d", gcount[i], i);
      end
    end
    next_cycle();
    idle();
  endtask

  task automatic test_hold();
    int unsigned e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req_i = (k >= 1) ? 4'b0101 : 4'b0100;
      gnt_i = (k == 5);
      @(negedge clk);
      checks++;
      if (add_o !== 32'h3000) begin
        failures++; $display("FAIL hold_add: got %h want 3000 at cycle %0d", add_o, k);
      end
      checks++;
      if (gnt_o !== ((k == 5) ? 4'b0100 : 4'b0000)) begin
        failures++; $display("FAIL hold_gnt: got %b at cycle %0d", gnt_o, k);
      end
      if (k == 5) sb.push_back(2);
      next_cycle();
    end
    req_i     = 4'b0001;
    gnt_i     = 1'b1;
    r_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    e = (sb.size() > 0) ? sb.pop_front() : 99;
    if (r_valid_o !== (4'b0001 << e)) begin
      failures++; $display("FAIL hold_resp: got %b want id %0d", r_valid_o, e);
    end
    checks++;
    if (gnt_o !== 4'b0001 || add_o !== 32'h1000) begin
      failures++; $display("FAIL hold_next: got %b/%h want 0001/1000", gnt_o, add_o);
    end
    sb.push_back(0);
    next_cycle();
    idle();
    r_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    e = (sb.size() > 0) ? sb.pop_front() : 99;
    if (r_valid_o !== (4'b0001 << e)) begin
      failures++; $display("FAIL hold_resp2: got %b want id %0d", r_valid_o, e);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_full();
    int unsigned e;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req_i = (k == 0) ? 4'b0001 : 4'b0010;
      gnt_i = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt_o !== req_i) begin
        failures++; $display("FAIL full_fill: got %b want %b", gnt_o, req_i);
      end
      sb.push_back(k);
      next_cycle();
    end
    req_i = 4'b0100;
    gnt_i = 1'b0;
    @(negedge clk);
    checks++;
    if (req_o !== 1'b0 || gnt_o !== 4'b0000) begin
      failures++; $display("FAIL full_block: got req=%b gnt=%b want 0/0000", req_o, gnt_o);
    end
    next_cycle();
    r_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    e = (sb.size() > 0) ? sb.pop_front() : 99;
    if (r_valid_o !== (4'b0001 << e)) begin
      failures++; $display("FAIL full_pop: got %b want id %0d", r_valid_o, e);
    end
    checks++;
    if (req_o !== 1'b0) begin
      failures++; $display("FAIL full_pop_req: got %b want 0", req_o);
    end
    next_cycle();
    r_valid_i = 1'b0;
    gnt_i     = 1'b1;
    @(negedge clk);
    checks++;
    if (req_o !== 1'b1 || gnt_o !== 4'b0100) begin
      failures++; $display("FAIL full_resume: got req=%b gnt=%b want 1/0100", req_o, gnt_o);
    end
    sb.push_back(2);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      idle();
      r_valid_i = 1'b1;
      @(negedge clk);
      checks++;
      e = (sb.size() > 0) ? sb.pop_front() : 99;
      if (r_valid_o !== (4'b0001 << e)) begin
        failures++; $display("FAIL full_drain: got %b want id %0d", r_valid_o, e);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_err();
    do_reset();
    r_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (r_valid_o !== 4'b0000) begin
      failures++; $display("FAIL err_rvalid: got %b want 0000", r_valid_o);
    end
    next_cycle();
    r_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      failures++; $display("FAIL err_set: got %b want 1", err_o);
    end
    for (int k = 0; k < 3; k++) next_cycle();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      failures++; $display("FAIL err_sticky: got %b want 1", err_o);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      failures++; $display("FAIL err_clear: got %b want 0", err_o);
    end
    req_i = 4'b1000;
    gnt_i = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o !== 4'b1000) begin
      failures++; $display("FAIL err_grant: got %b want 1000", gnt_o);
    end
    next_cycle();
    do_reset();
    r_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (r_valid_o !== 4'b0000) begin
      failures++; $display("FAIL err_midreset_rvalid: got %b want 0000", r_valid_o);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      failures++; $display("FAIL err_midreset: got %b want 1", err_o);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_hold();
    test_full();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
